// File: rtl/bus_transfer_ctrl_pkg.sv
// Shared encodings for the register-file bus master.
// Op and state codes are reused by the instruction decoder.
package bus_transfer_ctrl_pkg;

  localparam logic [1:0] OP_REG2REG = 2'b00;
  localparam logic [1:0] OP_IMM2REG = 2'b01;
  localparam logic [1:0] OP_REG2MEM = 2'b10;
  localparam logic [1:0] OP_MEM2REG = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_MOVE   = 2'b01;
  localparam logic [1:0] ST_MEM_WR = 2'b10;
  localparam logic [1:0] ST_MEM_RD = 2'b11;

  typedef struct packed {
    logic [1:0] op;
    logic [2:0] src;
    logic [2:0] dst;
    logic [7:0] imm;
    logic [7:0] addr;
  } xfer_cmd_t;

  function automatic logic [1:0] op_target(
    input logic [1:0] op
  );
    logic [1:0] st;
    st = ST_MOVE;
    if (op == OP_REG2MEM) st = ST_MEM_WR;
    if (op == OP_MEM2REG) st = ST_MEM_RD;
    return st;
  endfunction

endpackage

// File: rtl/bus_transfer_ctrl_watchdog.sv
// Memory-handshake watchdog: counts cycles without ack.
// Flags expiry in the last cycle the request may stay up.
module bus_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/bus_transfer_ctrl.sv
// Register-file bus master: sequences moves, immediates and
// memory transfers over the shared 8-bit tri-state bus.
module bus_transfer_ctrl
  import bus_transfer_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_src,
  input  logic [2:0] cmd_dst,
  input  logic [7:0] cmd_imm,
  input  logic [7:0] cmd_addr,
  output logic       rf_read_data,
  output logic       rf_write_data,
  output logic [2:0] rf_input_select,
  output logic [2:0] rf_output_select,
  inout  wire  [7:0] data_bus,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  output logic       busy,
  output logic       done,
  output logic       error
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  xfer_cmd_t  cmd;
  logic       done_q;
  logic       error_q;
  logic       expired;
  logic       drive_imm;

  logic is_idle;
  logic is_move;
  logic is_wr;
  logic is_rd;
  logic in_mem;

  assign is_idle = (state == ST_IDLE);
  assign is_move = (state == ST_MOVE);
  assign is_wr   = (state == ST_MEM_WR);
  assign is_rd   = (state == ST_MEM_RD);
  assign in_mem  = is_wr | is_rd;

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .clear    (!in_mem),
    .count_en (in_mem & !mem_ack),
    .expired  (expired)
  );

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      is_idle: if (cmd_valid) state_nxt = op_target(cmd_op);
      is_move: state_nxt = ST_IDLE;
      in_mem:  if (mem_ack || expired) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cmd     <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      done_q  <= is_move | (in_mem & mem_ack);
      error_q <= in_mem & !mem_ack & expired;
      if (is_idle && cmd_valid) begin
        cmd.op   <= cmd_op;
        cmd.src  <= cmd_src;
        cmd.dst  <= cmd_dst;
        cmd.imm  <= cmd_imm;
        cmd.addr <= cmd_addr;
      end
    end
  end

  // Read strobe in MEM_RD follows ack directly: memory owns the bus then.
  always_comb begin
    rf_read_data     = 1'b0;
    rf_write_data    = 1'b0;
    rf_input_select  = 3'd0;
    rf_output_select = 3'd0;
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    drive_imm        = 1'b0;
    unique case (1'b1)
      is_move: begin
        rf_read_data    = 1'b1;
        rf_input_select = cmd.dst;
        if (cmd.op == OP_REG2REG) begin
          rf_write_data    = 1'b1;
          rf_output_select = cmd.src;
        end else begin
          drive_imm = 1'b1;
        end
      end
      is_wr: begin
        rf_write_data    = 1'b1;
        rf_output_select = cmd.src;
        mem_req          = 1'b1;
        mem_we           = 1'b1;
      end
      is_rd: begin
        mem_req         = 1'b1;
        rf_read_data    = mem_ack;
        rf_input_select = cmd.dst;
      end
      default: ;
    endcase
  end

  assign data_bus  = drive_imm ? cmd.imm : 8'hzz;
  assign cmd_ready = is_idle;
  assign busy      = !is_idle;
  assign mem_addr  = cmd.addr;
  assign done      = done_q;
  assign error     = error_q;

endmodule
